// File: rtl/divmod_pkg.sv
// Shared constants for the iterative divider: FSM state encodings and a
// counter-width helper sized from the operand width.
package divmod_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bits needed to count down from w-1 to 0 (ceil(log2(w)), at least 1).
  function automatic int unsigned cnt_width(input int unsigned w);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 6; i++) begin
      if ((32'd1 << i) < w) n = i + 1;
    end
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/divmod_step.sv
// One restoring shift-subtract step: shifts the next dividend bit into the
// partial remainder and subtracts the divisor when it fits.
module divmod_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_partial_rem,
  input  logic             i_dividend_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_partial_rem_c,
  output logic             o_q_bit_c
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;

  // partial_rem < divisor holds on entry, so both results fit in WIDTH bits.
  assign w_shifted       = {i_partial_rem, i_dividend_bit};
  assign w_trial         = w_shifted - {1'b0, i_divisor};
  assign o_q_bit_c       = (w_shifted >= {1'b0, i_divisor});
  assign o_partial_rem_c = o_q_bit_c ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divmod.sv
// Iterative unsigned divider/modulo, one quotient bit per clock, start/done handshake.
// Optional SEQ_DIVMOD_EARLY_EXIT_EN: finish at once when dividend < divisor.
module seq_divmod
  import divmod_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = cnt_width(WIDTH);

  logic [1:0]       r_state,  w_state_nxt;
  logic [CW-1:0]    r_cnt,    w_cnt_nxt;
  logic [WIDTH-1:0] r_rem,    w_rem_nxt;
  logic [WIDTH-1:0] r_dvd,    w_dvd_nxt;
  logic [WIDTH-1:0] r_dvs,    w_dvs_nxt;
  logic             r_short,  w_short_nxt;
  logic [WIDTH-1:0] r_quot,   w_quot_nxt;
  logic [WIDTH-1:0] r_remo,   w_remo_nxt;
  logic             r_dbz,    w_dbz_nxt;
  logic             r_done,   w_done_nxt;
  logic             r_ready,  r_busy;
  logic [WIDTH-1:0] w_step_rem;
  logic             w_step_q;
  logic             w_short_c;

  divmod_step #(.WIDTH(WIDTH)) u_step (
    .i_partial_rem  (r_rem),
    .i_dividend_bit (r_dvd[WIDTH-1]),
    .i_divisor      (r_dvs),
    .o_partial_rem_c(w_step_rem),
    .o_q_bit_c      (w_step_q)
  );

  // Degenerate operands skip the shift loop but still spend one CALC cycle,
  // so done lands one edge after acceptance.
`ifdef SEQ_DIVMOD_EARLY_EXIT_EN
  assign w_short_c = (divisor == '0) || (dividend < divisor);
`else
  assign w_short_c = (divisor == '0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rem_nxt   = r_rem;
    w_dvd_nxt   = r_dvd;
    w_dvs_nxt   = r_dvs;
    w_short_nxt = r_short;
    w_quot_nxt  = r_quot;
    w_remo_nxt  = r_remo;
    w_dbz_nxt   = r_dbz;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_CALC;
          w_cnt_nxt   = CW'(WIDTH - 1);
          w_rem_nxt   = '0;
          w_dvd_nxt   = dividend;
          w_dvs_nxt   = divisor;
          w_short_nxt = w_short_c;
          w_dbz_nxt   = 1'b0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (r_short) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
          w_quot_nxt  = (r_dvs == '0) ? '1 : '0;
          w_remo_nxt  = r_dvd;
          w_dbz_nxt   = (r_dvs == '0);
        end else begin
          // r_dvd doubles as the quotient register as dividend bits shift out.
          w_rem_nxt = w_step_rem;
          w_dvd_nxt = {r_dvd[WIDTH-2:0], w_step_q};
          if (r_cnt == '0) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
            w_quot_nxt  = {r_dvd[WIDTH-2:0], w_step_q};
            w_remo_nxt  = w_step_rem;
          end else begin
            w_cnt_nxt = r_cnt - CW'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_short <= 1'b0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_dbz   <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rem   <= w_rem_nxt;
      r_dvd   <= w_dvd_nxt;
      r_dvs   <= w_dvs_nxt;
      r_short <= w_short_nxt;
      r_quot  <= w_quot_nxt;
      r_remo  <= w_remo_nxt;
      r_dbz   <= w_dbz_nxt;
      r_done  <= w_done_nxt;
      r_ready <= (w_state_nxt != ST_CALC);
      r_busy  <= (w_state_nxt == ST_CALC);
    end
  end

  assign ready       = r_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divmod.sv
// Scoreboard bench for seq_divmod (WIDTH=8): driver pushes model results,
// a negedge monitor pops and compares on every done pulse.
module tb_seq_divmod;

  localparam int unsigned W = 8;
  localparam int unsigned T = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         ready, busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  seq_divmod #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #(T/2) clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    longint       t;
    string        tag;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division, divide-by-zero convention, latency from operand class.
  function automatic exp_t model(input int unsigned a, input int unsigned b,
                                 input longint t_acc, input string tag);
    exp_t e;
    int unsigned lat;
    if (b == 0) begin
      e.q = '1; e.r = W'(a); e.dbz = 1'b1; lat = 1;
    end else begin
      e.q = W'(a / b); e.r = W'(a % b); e.dbz = 1'b0; lat = W;
`ifdef SEQ_DIVMOD_EARLY_EXIT_EN
      if (a < b) lat = 1;
`endif
    end
    e.t   = t_acc + longint'(lat * T) + longint'(T / 2);
    e.tag = tag;
    return e;
  endfunction

  task automatic issue(input int unsigned a, input int unsigned b, input bit push, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      chk({tag, "_ready_timeout"}, 0, 1);
      return;
    end
    start = 1'b1;
    dividend = W'(a);
    divisor = W'(b);
    @(posedge clk);
    if (push) sbq.push_back(model(a, b, $time, tag));
    #1;
    start = 1'b0;
    dividend = W'($urandom);
    divisor = W'($urandom);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk({mon_e.tag, "_q"}, longint'(quotient), longint'(mon_e.q));
        chk({mon_e.tag, "_r"}, longint'(remainder), longint'(mon_e.r));
        chk({mon_e.tag, "_dbz"}, longint'(div_by_zero), longint'(mon_e.dbz));
        chk({mon_e.tag, "_done_time"}, longint'($time), mon_e.t);
        chk({mon_e.tag, "_ready_in_done"}, longint'(ready), 1);
      end
    end
  end

  initial begin
    int n;
    int unsigned a, b;

    repeat (3) @(negedge clk);
    chk("rst_ready", longint'(ready), 1);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_q", longint'(quotient), 0);
    chk("rst_r", longint'(remainder), 0);
    chk("rst_dbz", longint'(div_by_zero), 0);
    rst_n = 1'b1;

    // 237/10 with busy held for exactly W cycles
    issue(237, 10, 1'b1, "d237_10");
    for (int i = 0; i < int'(W); i++) begin
      @(negedge clk);
      chk("busy_window", longint'(busy), 1);
    end
    @(negedge clk);
    chk("busy_after", longint'(busy), 0);

    for (int i = 0; i < 16; i++) issue(i, 10, 1'b1, "sweep_mod10");

    issue(200, 0, 1'b1, "div0");
    issue(10, 3, 1'b1, "after_div0");
    @(negedge clk);
    chk("dbz_cleared_on_accept", longint'(div_by_zero), 0);

    // back-to-back: second start lands in the DONE cycle of the first
    issue(255, 1, 1'b1, "b2b_first");
    issue(99, 9, 1'b1, "b2b_second");

    issue(5, 60, 1'b1, "small_over_big");

    // start during CALC with other operands must be ignored
    issue(200, 7, 1'b1, "ignored_start");
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;

    // reset in CALC cycle 4: abandon without a done pulse
    issue(123, 4, 1'b0, "rst_mid");
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_done", longint'(done), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_ready", longint'(ready), 1);
    chk("midrst_q", longint'(quotient), 0);
    chk("midrst_r", longint'(remainder), 0);
    chk("midrst_dbz", longint'(div_by_zero), 0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 12);
      issue(a, b, 1'b1, "random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) chk("drain_pending", longint'(sbq.size()), 0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
